mul_unit: RTL and testbench

MUL_UNIT -- requirements
Module: mul_unit

---
 rtl/mul_unit_pkg.sv | 22 ++
 rtl/mul_unit.sv | 112 +++++++++++
 tb/tb_mul_unit.sv | 186 ++++++++++++++++++
 3 files changed

// File: rtl/mul_unit_pkg.sv
// Shared multiplier definitions: datapath width and the mulctl op encodings.
// The controller imports the same package, so both sides agree on the codes.
package mul_unit_pkg;

    localparam int XLEN_DEFAULT = 32;

    localparam logic [1:0] MULCTL_MUL    = 2'b00;
    localparam logic [1:0] MULCTL_MULH   = 2'b01;
    localparam logic [1:0] MULCTL_MULHSU = 2'b10;
    localparam logic [1:0] MULCTL_MULHU  = 2'b11;

    // rs1 is treated as signed for MULH and MULHSU.
    function automatic logic op_a_signed(input logic [1:0] ctl);
        return (ctl == MULCTL_MULH) || (ctl == MULCTL_MULHSU);
    endfunction

    // rs2 is treated as signed for MULH only.
    function automatic logic op_b_signed(input logic [1:0] ctl);
        return (ctl == MULCTL_MULH);
    endfunction

endpackage

// File: rtl/mul_unit.sv
// Sequential radix-2 shift-add multiplier for MUL/MULH/MULHSU/MULHU.
//
// Handshake: start is a single-cycle request strobe, accepted only on an edge
// where the unit is idle (busy low); it is ignored, not queued, while busy.
// Operands and mulctl are captured on the accepting edge. Completion is a
// one-cycle exdone pulse; result is valid from that pulse and holds until the
// next completion. There is no backpressure from the controller.
module mul_unit
    import mul_unit_pkg::*;
#(
    parameter int XLEN = XLEN_DEFAULT
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic [1:0]      mulctl,
    input  logic [XLEN-1:0] a,
    input  logic [XLEN-1:0] b,
    output logic [XLEN-1:0] result,
    output logic            exdone,
    output logic            busy
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    localparam logic [5:0] LAST_STEP = 6'(XLEN - 1);

    state_t              state;
    logic [1:0]          op_q;
    logic                neg_q;
    logic [2*XLEN-1:0]   mcand_q;
    logic [XLEN-1:0]     mplier_q;
    logic [2*XLEN-1:0]   acc;
    logic [5:0]          cnt;

    // Operand magnitudes and product sign derived from the live inputs; only
    // used on the accepting edge.
    logic                a_neg;
    logic                b_neg;
    logic [XLEN-1:0]     a_mag;
    logic [XLEN-1:0]     b_mag;
    logic [2*XLEN-1:0]   prod;

    assign a_neg = op_a_signed(mulctl) && a[XLEN-1];
    assign b_neg = op_b_signed(mulctl) && b[XLEN-1];
    assign a_mag = a_neg ? -a : a;
    assign b_mag = b_neg ? -b : b;
    assign prod  = neg_q ? -acc : acc;

    // Control FSM plus shift-add datapath; every output is a register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= S_IDLE;
            op_q     <= MULCTL_MUL;
            neg_q    <= 1'b0;
            mcand_q  <= '0;
            mplier_q <= '0;
            acc      <= '0;
            cnt      <= '0;
            result   <= '0;
            exdone   <= 1'b0;
            busy     <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (start) begin
                        op_q     <= mulctl;
                        neg_q    <= a_neg ^ b_neg;
                        mcand_q  <= {{XLEN{1'b0}}, a_mag};
                        mplier_q <= b_mag;
                        acc      <= '0;
                        cnt      <= '0;
                        busy     <= 1'b1;
                        state    <= S_RUN;
                    end
                end
                S_RUN: begin
                    // One multiplier bit per cycle, always XLEN steps.
                    if (mplier_q[0]) begin
                        acc <= acc + mcand_q;
                    end
                    mcand_q  <= mcand_q << 1;
                    mplier_q <= mplier_q >> 1;
                    cnt      <= cnt + 6'd1;
                    if (cnt == LAST_STEP) begin
                        state <= S_DONE;
                    end
                end
                S_DONE: begin
                    // First DONE cycle publishes the result, second retires.
                    if (!exdone) begin
                        result <= (op_q == MULCTL_MUL) ? prod[XLEN-1:0]
                                                       : prod[2*XLEN-1:XLEN];
                        exdone <= 1'b1;
                    end else begin
                        exdone <= 1'b0;
                        busy   <= 1'b0;
                        state  <= S_IDLE;
                    end
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mul_unit.sv
// Self-checking bench for mul_unit: fixed vectors, multi-cycle corner
// sequences, and random operations against an arithmetic reference model.
module tb_mul_unit;
    import mul_unit_pkg::*;

    localparam int XLEN = 32;
    localparam int LAT  = XLEN + 1;

    logic            clk;
    logic            rst;
    logic            start;
    logic [1:0]      mulctl;
    logic [XLEN-1:0] a;
    logic [XLEN-1:0] b;
    logic [XLEN-1:0] result;
    logic            exdone;
    logic            busy;

    int n_vec;
    int n_err;
    logic [XLEN-1:0] last_exp;

    typedef struct {
        logic [1:0]  ctl;
        logic [31:0] av;
        logic [31:0] bv;
        logic [31:0] exp;
        string       name;
    } vec_t;

    vec_t vecs[8];

    mul_unit #(.XLEN(XLEN)) dut (
        .clk    (clk),
        .rst    (rst),
        .start  (start),
        .mulctl (mulctl),
        .a      (a),
        .b      (b),
        .result (result),
        .exdone (exdone),
        .busy   (busy)
    );

    // Clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference: full-width integer product, signedness from the op.
    function automatic logic [31:0] ref_mul(input logic [1:0] ctl,
                                            input logic [31:0] av,
                                            input logic [31:0] bv);
        longint sa;
        longint sb;
        logic [63:0] p;
        sa = (ctl == MULCTL_MULH || ctl == MULCTL_MULHSU) ? longint'($signed(av)) : longint'(av);
        sb = (ctl == MULCTL_MULH) ? longint'($signed(bv)) : longint'(bv);
        p  = 64'(sa * sb);
        return (ctl == MULCTL_MUL) ? p[31:0] : p[63:32];
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    // Issue one op; start is sampled on edge k. poke_at >= 0 re-pulses start
    // with 3*3 on edge k+poke_at; scramble changes the inputs every cycle.
    task automatic run_op(input logic [1:0] ctl, input logic [31:0] av,
                          input logic [31:0] bv, input logic [31:0] exp,
                          input string tag, input int poke_at, input bit scramble);
        int n;
        @(negedge clk);
        start = 1'b1; mulctl = ctl; a = av; b = bv;
        @(negedge clk);
        start = 1'b0;
        n = 0;
        check({tag, " busy_after_accept"}, 32'(busy), 32'd1);
        while (!exdone && n < 100) begin
            start = 1'b0;
            if (scramble) begin
                a = $urandom; b = $urandom; mulctl = 2'($urandom_range(0, 3));
            end
            if (n == poke_at - 1) begin
                start = 1'b1; a = 32'd3; b = 32'd3;
            end
            if (n == 16) check({tag, " result_hold_run"}, result, last_exp);
            @(negedge clk);
            n++;
        end
        start = 1'b0;
        check({tag, " latency"}, 32'(n), 32'(LAT));
        check({tag, " result"}, result, exp);
        check({tag, " busy_at_done"}, 32'(busy), 32'd1);
        @(negedge clk);
        check({tag, " exdone_one_cycle"}, 32'(exdone), 32'd0);
        check({tag, " busy_fall"}, 32'(busy), 32'd0);
        check({tag, " result_hold_idle"}, result, exp);
        last_exp = exp;
    endtask

    initial begin
        int busy_seen;
        logic [1:0]  rc;
        logic [31:0] ra;
        logic [31:0] rb;
        n_vec = 0; n_err = 0; last_exp = '0;
        rst = 1'b1; start = 1'b0; mulctl = 2'b00; a = '0; b = '0;

        vecs[0] = '{MULCTL_MUL,    32'd7,          32'd6,          32'h0000002A, "mul_7x6"};
        vecs[1] = '{MULCTL_MULH,   32'h80000000,   32'h80000000,   32'h40000000, "mulh_min"};
        vecs[2] = '{MULCTL_MULH,   32'hFFFFFFFF,   32'hFFFFFFFF,   32'h00000000, "mulh_m1"};
        vecs[3] = '{MULCTL_MULHU,  32'hFFFFFFFF,   32'hFFFFFFFF,   32'hFFFFFFFE, "mulhu_max"};
        vecs[4] = '{MULCTL_MULHSU, 32'hFFFFFFFF,   32'hFFFFFFFF,   32'hFFFFFFFF, "mulhsu_m1"};
        vecs[5] = '{MULCTL_MUL,    32'd0,          32'd0,          32'h00000000, "mul_zero"};
        vecs[6] = '{MULCTL_MULHU,  32'h00010000,   32'h00010000,   32'h00000001, "mulhu_2p16"};
        vecs[7] = '{MULCTL_MULH,   32'hFFFFFFFE,   32'h00000003,   32'hFFFFFFFF, "mulh_neg"};

        // Reset state
        repeat (3) @(negedge clk);
        check("reset_result", result, 32'd0);
        check("reset_exdone", 32'(exdone), 32'd0);
        check("reset_busy", 32'(busy), 32'd0);

        // start coincident with rst is ignored
        start = 1'b1;
        @(negedge clk);
        check("start_in_reset_busy", 32'(busy), 32'd0);
        rst = 1'b0; start = 1'b0;
        @(negedge clk);
        check("start_in_reset_stays_idle", 32'(busy), 32'd0);

        // Fixed vectors
        for (int i = 0; i < 8; i++) begin
            run_op(vecs[i].ctl, vecs[i].av, vecs[i].bv, vecs[i].exp, vecs[i].name, -1, 1'b0);
        end

        // Re-pulsed start during RUN is dropped
        run_op(MULCTL_MUL, 32'd7, 32'd6, 32'h2A, "repulse", 10, 1'b0);
        busy_seen = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (busy || exdone) busy_seen++;
        end
        check("repulse_no_second_op", 32'(busy_seen), 32'd0);

        // Operands scrambled during RUN
        run_op(MULCTL_MUL,   32'h00010000, 32'h00010000, 32'h0, "scramble_mul", -1, 1'b1);
        run_op(MULCTL_MULHU, 32'h00010000, 32'h00010000, 32'h1, "scramble_mulhu", -1, 1'b1);

        // Reset in the middle of RUN (start at edge 0, rst at edge 15)
        @(negedge clk);
        start = 1'b1; mulctl = MULCTL_MUL; a = 32'd7; b = 32'd6;
        @(negedge clk);
        start = 1'b0;
        repeat (14) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check("midrun_rst_busy", 32'(busy), 32'd0);
        check("midrun_rst_exdone", 32'(exdone), 32'd0);
        check("midrun_rst_result", result, 32'd0);
        rst = 1'b0;
        last_exp = '0;
        run_op(MULCTL_MUL, 32'd5, 32'd5, 32'h19, "after_rst_5x5", -1, 1'b0);

        // Random operations against the reference model
        for (int i = 0; i < 30; i++) begin
            rc = 2'($urandom_range(0, 3));
            case ($urandom_range(0, 3))
                0: ra = 32'h80000000;
                1: ra = 32'hFFFFFFFF;
                2: ra = 32'($urandom_range(0, 255));
                default: ra = $urandom;
            endcase
            rb = ($urandom_range(0, 3) == 0) ? 32'h80000000 : $urandom;
            run_op(rc, ra, rb, ref_mul(rc, ra, rb), $sformatf("rand%0d", i), -1, 1'b0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
